// File: rtl/ex_forwarding_unit_pkg.sv
// Shared pipeline definitions for EX-stage forwarding: register width and
// the 2-bit ALU operand-select encoding.
package ex_forwarding_unit_pkg;

    localparam int REG_W = 3;

    typedef logic [1:0] fwd_sel_t;

    localparam fwd_sel_t FWD_REGFILE = 2'b00;
    localparam fwd_sel_t FWD_EXMEM   = 2'b10;
    localparam fwd_sel_t FWD_MEMWB   = 2'b01;

endpackage

// File: rtl/ex_forwarding_unit_fwd_select.sv
// Per-operand forwarding decision: compares one source register against the
// EX/MEM and MEM/WB destinations and picks the newest matching producer.
module fwd_select
    import ex_forwarding_unit_pkg::*;
#(
    parameter int REG_W = ex_forwarding_unit_pkg::REG_W
) (
    input  logic [REG_W-1:0] src_i,
    input  logic             exMemRegWrite_i,
    input  logic [REG_W-1:0] exMemDestReg_i,
    input  logic             memWbRegWrite_i,
    input  logic [REG_W-1:0] memWbDestReg_i,
    output fwd_sel_t         fwdSel_o
);

    logic hitEm;
    logic hitMw;

    // r0 is hardwired to zero, so a write to it must never be forwarded
    assign hitEm = exMemRegWrite_i && (exMemDestReg_i != '0) && (exMemDestReg_i == src_i);
    assign hitMw = memWbRegWrite_i && (memWbDestReg_i != '0) && (memWbDestReg_i == src_i);

    always_comb begin
        fwdSel_o = FWD_REGFILE;
        if (hitEm) begin
            fwdSel_o = FWD_EXMEM;
        end else if (hitMw) begin
            fwdSel_o = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/ex_forwarding_unit.sv
// EX-stage forwarding control: operand selects for both ALU inputs plus
// saturating counters of cycles that forwarded from EX/MEM and MEM/WB.
module ex_forwarding_unit
    import ex_forwarding_unit_pkg::*;
#(
    parameter int REG_W   = ex_forwarding_unit_pkg::REG_W,
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [REG_W-1:0]   ID_EX_Rs,
    input  logic [REG_W-1:0]   ID_EX_Rt,
    input  logic               EX_MEM_RegWrite,
    input  logic [REG_W-1:0]   EX_MEM_DestReg,
    input  logic               MEM_WB_RegWrite,
    input  logic [REG_W-1:0]   MEM_WB_DestReg,
    output logic [1:0]         ForwardA,
    output logic [1:0]         ForwardB,
    output logic [COUNT_W-1:0] fwd_cnt_exmem,
    output logic [COUNT_W-1:0] fwd_cnt_memwb
);

    fwd_sel_t selA;
    fwd_sel_t selB;
    logic [COUNT_W-1:0] cntExmem_q, cntExmem_d;
    logic [COUNT_W-1:0] cntMemwb_q, cntMemwb_d;
    logic anyExmem;
    logic anyMemwb;

    fwd_select #(.REG_W(REG_W)) uSelA (
        .src_i           (ID_EX_Rs),
        .exMemRegWrite_i (EX_MEM_RegWrite),
        .exMemDestReg_i  (EX_MEM_DestReg),
        .memWbRegWrite_i (MEM_WB_RegWrite),
        .memWbDestReg_i  (MEM_WB_DestReg),
        .fwdSel_o        (selA)
    );

    fwd_select #(.REG_W(REG_W)) uSelB (
        .src_i           (ID_EX_Rt),
        .exMemRegWrite_i (EX_MEM_RegWrite),
        .exMemDestReg_i  (EX_MEM_DestReg),
        .memWbRegWrite_i (MEM_WB_RegWrite),
        .memWbDestReg_i  (MEM_WB_DestReg),
        .fwdSel_o        (selB)
    );

    assign ForwardA = rst_n ? selA : FWD_REGFILE;
    assign ForwardB = rst_n ? selB : FWD_REGFILE;

    assign anyExmem = (ForwardA == FWD_EXMEM) || (ForwardB == FWD_EXMEM);
    assign anyMemwb = (ForwardA == FWD_MEMWB) || (ForwardB == FWD_MEMWB);

    // Counters hold at all-ones instead of wrapping
    always_comb begin
        cntExmem_d = cntExmem_q;
        cntMemwb_d = cntMemwb_q;
        if (anyExmem && (cntExmem_q != '1)) begin
            cntExmem_d = cntExmem_q + COUNT_W'(1);
        end
        if (anyMemwb && (cntMemwb_q != '1)) begin
            cntMemwb_d = cntMemwb_q + COUNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cntExmem_q <= '0;
            cntMemwb_q <= '0;
        end else begin
            cntExmem_q <= cntExmem_d;
            cntMemwb_q <= cntMemwb_d;
        end
    end

    assign fwd_cnt_exmem = cntExmem_q;
    assign fwd_cnt_memwb = cntMemwb_q;

endmodule

// File: tb/tb_ex_forwarding_unit.sv
// Self-checking bench for ex_forwarding_unit: directed vector table, reset and
// saturation sequences, and random vectors against a reference decision model.
module tb_ex_forwarding_unit;

    typedef struct {
        logic       rst;
        logic [2:0] rs;
        logic [2:0] rt;
        logic       emW;
        logic [2:0] emD;
        logic       mwW;
        logic [2:0] mwD;
        logic [1:0] expA;
        logic [1:0] expB;
    } vec_t;

    typedef struct {
        logic [1:0]  a;
        logic [1:0]  b;
        logic [15:0] em;
        logic [15:0] mw;
        logic [1:0]  em2;
        logic [1:0]  mw2;
    } exp_t;

    logic        clk;
    logic        rst_n;
    logic [2:0]  idExRs;
    logic [2:0]  idExRt;
    logic        exMemRegWrite;
    logic [2:0]  exMemDestReg;
    logic        memWbRegWrite;
    logic [2:0]  memWbDestReg;
    logic [1:0]  forwardA, forwardB, forwardA2, forwardB2;
    logic [15:0] cntExmem, cntMemwb;
    logic [1:0]  cntExmem2, cntMemwb2;

    int compared = 0;
    int mismatched = 0;
    exp_t sbQ[$];
    logic [15:0] modelEm = '0;
    logic [15:0] modelMw = '0;
    logic [1:0]  modelEm2 = '0;
    logic [1:0]  modelMw2 = '0;
    vec_t vecs[17];

    ex_forwarding_unit #(.REG_W(3), .COUNT_W(16)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ID_EX_Rs        (idExRs),
        .ID_EX_Rt        (idExRt),
        .EX_MEM_RegWrite (exMemRegWrite),
        .EX_MEM_DestReg  (exMemDestReg),
        .MEM_WB_RegWrite (memWbRegWrite),
        .MEM_WB_DestReg  (memWbDestReg),
        .ForwardA        (forwardA),
        .ForwardB        (forwardB),
        .fwd_cnt_exmem   (cntExmem),
        .fwd_cnt_memwb   (cntMemwb)
    );

    ex_forwarding_unit #(.REG_W(3), .COUNT_W(2)) dutSat (
        .clk             (clk),
        .rst_n           (rst_n),
        .ID_EX_Rs        (idExRs),
        .ID_EX_Rt        (idExRt),
        .EX_MEM_RegWrite (exMemRegWrite),
        .EX_MEM_DestReg  (exMemDestReg),
        .MEM_WB_RegWrite (memWbRegWrite),
        .MEM_WB_DestReg  (memWbDestReg),
        .ForwardA        (forwardA2),
        .ForwardB        (forwardB2),
        .fwd_cnt_exmem   (cntExmem2),
        .fwd_cnt_memwb   (cntMemwb2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic vec_t mk(logic rst, logic [2:0] rs, logic [2:0] rt,
                                logic emW, logic [2:0] emD, logic mwW, logic [2:0] mwD,
                                logic [1:0] expA, logic [1:0] expB);
        vec_t v;
        v.rst = rst; v.rs = rs; v.rt = rt;
        v.emW = emW; v.emD = emD; v.mwW = mwW; v.mwD = mwD;
        v.expA = expA; v.expB = expB;
        return v;
    endfunction

    // Reference decision written straight from the forwarding rules
    function automatic logic [1:0] refFwd(logic emW, logic [2:0] emD, logic mwW,
                                          logic [2:0] mwD, logic [2:0] src);
        if (emW && emD != 3'd0 && emD == src) return 2'b10;
        if (mwW && mwD != 3'd0 && mwD == src) return 2'b01;
        return 2'b00;
    endfunction

    task automatic compare(input string name, input logic [15:0] act, input logic [15:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    // Drive one vector, queue the expected outputs, then advance the counter model
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        logic hitEm, hitMw;
        @(negedge clk);
        rst_n         = v.rst;
        idExRs        = v.rs;
        idExRt        = v.rt;
        exMemRegWrite = v.emW;
        exMemDestReg  = v.emD;
        memWbRegWrite = v.mwW;
        memWbDestReg  = v.mwD;
        e.a = v.expA; e.b = v.expB;
        e.em = modelEm; e.mw = modelMw; e.em2 = modelEm2; e.mw2 = modelMw2;
        sbQ.push_back(e);
        hitEm = (v.expA == 2'b10) || (v.expB == 2'b10);
        hitMw = (v.expA == 2'b01) || (v.expB == 2'b01);
        if (!v.rst) begin
            modelEm = '0; modelMw = '0; modelEm2 = '0; modelMw2 = '0;
        end else begin
            if (hitEm && modelEm != 16'hFFFF) modelEm = modelEm + 16'd1;
            if (hitMw && modelMw != 16'hFFFF) modelMw = modelMw + 16'd1;
            if (hitEm && modelEm2 != 2'b11) modelEm2 = modelEm2 + 2'd1;
            if (hitMw && modelMw2 != 2'b11) modelMw2 = modelMw2 + 2'd1;
        end
    endtask

    task automatic checkOutput(input int idx);
        exp_t e;
        #1;
        if (sbQ.size() == 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL scoreboard_empty: vector %0d had no expected entry", idx);
            return;
        end
        e = sbQ.pop_front();
        compare($sformatf("ForwardA[%0d]", idx), {14'd0, forwardA}, {14'd0, e.a});
        compare($sformatf("ForwardB[%0d]", idx), {14'd0, forwardB}, {14'd0, e.b});
        compare($sformatf("cnt_exmem[%0d]", idx), cntExmem, e.em);
        compare($sformatf("cnt_memwb[%0d]", idx), cntMemwb, e.mw);
        compare($sformatf("sat_cnt_exmem[%0d]", idx), {14'd0, cntExmem2}, {14'd0, e.em2});
        compare($sformatf("sat_cnt_memwb[%0d]", idx), {14'd0, cntMemwb2}, {14'd0, e.mw2});
    endtask

    initial begin
        rst_n = 1'b0;
        idExRs = 3'd1; idExRt = 3'd7;
        exMemRegWrite = 1'b1; exMemDestReg = 3'd1;
        memWbRegWrite = 1'b1; memWbDestReg = 3'd7;

        //              rst  rs    rt    emW   emD   mwW   mwD   expA   expB
        vecs[0]  = mk(1'b1, 3'd1, 3'd7, 1'b0, 3'd1, 1'b0, 3'd1, 2'b00, 2'b00);
        vecs[1]  = mk(1'b1, 3'd1, 3'd7, 1'b0, 3'd1, 1'b1, 3'd1, 2'b01, 2'b00);
        vecs[2]  = mk(1'b1, 3'd1, 3'd7, 1'b1, 3'd1, 1'b1, 3'd1, 2'b10, 2'b00);
        vecs[3]  = mk(1'b1, 3'd1, 3'd7, 1'b1, 3'd7, 1'b1, 3'd1, 2'b01, 2'b10);
        vecs[4]  = mk(1'b1, 3'd1, 3'd7, 1'b0, 3'd7, 1'b1, 3'd7, 2'b00, 2'b01);
        vecs[5]  = mk(1'b1, 3'd1, 3'd7, 1'b0, 3'd7, 1'b1, 3'd3, 2'b00, 2'b00);
        vecs[6]  = mk(1'b1, 3'd0, 3'd0, 1'b1, 3'd0, 1'b1, 3'd0, 2'b00, 2'b00);
        vecs[7]  = mk(1'b1, 3'd2, 3'd2, 1'b1, 3'd2, 1'b1, 3'd2, 2'b10, 2'b10);
        vecs[8]  = mk(1'b1, 3'd5, 3'd5, 1'b0, 3'd1, 1'b1, 3'd5, 2'b01, 2'b01);
        vecs[9]  = mk(1'b0, 3'd1, 3'd2, 1'b1, 3'd1, 1'b1, 3'd2, 2'b00, 2'b00);
        vecs[10] = mk(1'b1, 3'd1, 3'd2, 1'b1, 3'd1, 1'b1, 3'd2, 2'b10, 2'b01);
        vecs[11] = mk(1'b1, 3'd1, 3'd2, 1'b1, 3'd1, 1'b1, 3'd2, 2'b10, 2'b01);
        vecs[12] = mk(1'b1, 3'd1, 3'd2, 1'b1, 3'd1, 1'b1, 3'd2, 2'b10, 2'b01);
        vecs[13] = mk(1'b1, 3'd1, 3'd2, 1'b1, 3'd1, 1'b1, 3'd2, 2'b10, 2'b01);
        vecs[14] = mk(1'b1, 3'd1, 3'd2, 1'b1, 3'd1, 1'b1, 3'd2, 2'b10, 2'b01);
        vecs[15] = mk(1'b1, 3'd4, 3'd6, 1'b1, 3'd6, 1'b0, 3'd4, 2'b00, 2'b10);
        vecs[16] = mk(1'b1, 3'd3, 3'd3, 1'b1, 3'd5, 1'b1, 3'd3, 2'b01, 2'b01);

        // Hold reset with a live hazard so counters start from a known zero
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        compare("ForwardA_in_reset", {14'd0, forwardA}, 16'd0);
        compare("ForwardB_in_reset", {14'd0, forwardB}, 16'd0);
        compare("cnt_exmem_after_reset", cntExmem, 16'd0);
        compare("cnt_memwb_after_reset", cntMemwb, 16'd0);

        for (int i = 0; i < 17; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end

        // Random hazards scored against the reference decision
        for (int i = 0; i < 40; i++) begin
            vec_t v;
            v.rst = 1'b1;
            v.rs  = 3'($urandom_range(0, 7));
            v.rt  = 3'($urandom_range(0, 7));
            v.emW = 1'($urandom_range(0, 1));
            v.emD = 3'($urandom_range(0, 7));
            v.mwW = 1'($urandom_range(0, 1));
            v.mwD = 3'($urandom_range(0, 7));
            v.expA = refFwd(v.emW, v.emD, v.mwW, v.mwD, v.rs);
            v.expB = refFwd(v.emW, v.emD, v.mwW, v.mwD, v.rt);
            applyStimulus(v);
            checkOutput(100 + i);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
